work_loader: RTL
================

# work_loader

Upstream feeder for the miner core. It receives a byte stream over a valid/ready handshake and hunts for a sync byte. It then assembles the following 53 payload bytes into the 420-bit work word (block number, previous hash, transactions, difficulty) and presents that word to the miner with a hold-until-acknowledged handshake. Malformed or stalled frames are discarded and counted.

## Interface
- SYNC_BYTE, 8'hA5, frame start marker
- TIMEOUT, 1000, max cycles between accepted payload bytes before the partial frame is dropped (≥1)
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-low reset
- rx_data  input  8  incoming byte
- rx_valid  input  1  rx_data valid this cycle
- rx_ready  output  1  loader accepts a byte this cycle
- work_data  output  420  assembled work word: [419:388] block number, [387:132] prev hash, [131:4] transactions, [3:0] difficulty
- work_valid  output  1  work_data holds a complete frame
- work_ack  input  1  miner has taken the work; releases the loader
- err_count  output  8  saturating count of dropped frames

## Operation
- A transfer occurs when rx_valid && rx_ready.
- States:
  - HUNT: rx_ready=1. A byte equal to SYNC_BYTE moves to LOAD with idx=0. Any other byte is discarded silently and is not an error.
  - LOAD: rx_ready=1. Each transfer shifts the byte into a 424-bit shift register, MSB-first, and increments idx.
    - Payload byte 0 supplies bits [423:416]. Its upper nibble must be 0. If nonzero, the frame is dropped, err_count increments, and the state returns to HUNT. The shift register is not committed.
    - A SYNC_BYTE value inside the payload is ordinary data.
    - On the transfer with idx=52: work_data ← shift[419:0] including the final byte, work_valid←1, next state HOLD.
  - HOLD: rx_ready=0. work_data and work_valid stay stable. work_ack=1 sets work_valid←0 and next state HUNT.
- work_ack in HUNT or LOAD is ignored.
- Timeout (LOAD only): the gap counter clears on each transfer and on entry to LOAD, and increments on every other cycle. When it reaches TIMEOUT: drop the frame, err_count increments, state returns to HUNT. No byte is accepted on that cycle; rx_ready is 0 that cycle.
- err_count saturates at 255.
- work_data is written only on frame completion. It retains its last frame after ack.
- Reset mid-frame or in HOLD discards all progress. No error is counted.

## Timing
- During reset and on the first cycle after it: rx_ready=0, work_valid=0, work_data=0, err_count=0, state=HUNT, idx=0, gap counter=0. From the next cycle onward, rx_ready follows the state.
- rx_ready is a registered function of state. It is combinationally independent of rx_valid.
- The last payload byte accepted in cycle N gives work_valid=1 and new work_data in cycle N+1, and rx_ready=0 from N+1.
- work_ack sampled high in cycle M gives work_valid=0 and rx_ready=1 in M+1. A sync byte can be accepted in M+1.
- Minimum frame time is 54 accepted bytes. Best-case throughput is one frame per 54 + 1 (ack) cycles.
- A transfer and timeout expiry never coincide: the expiry cycle forces rx_ready=0.
- err_count updates one cycle after the offending byte or expiry.

## Test plan
- Back-to-back frame: 0xA5, then 0x0A followed by 52 bytes of 0x00..0x33. Then work_valid=1 one cycle after the last byte, work_data[419:412]=0xA0 pattern checked bit-exact, difficulty=0x3 (low nibble of final byte 0x33), rx_ready=0 until work_ack. Ack sets work_valid=0 next cycle.
- Garbage before sync: 0x00, 0xFF, 0x5A, then a valid frame. Frame is captured correctly and err_count stays 0.
- Bad nibble: sync, then 0xF0. err_count=1, state returns to HUNT, and a following valid frame is accepted.
- Timeout with TIMEOUT=8: sync plus 10 payload bytes, then rx_valid=0 for 8 cycles. err_count increments, rx_ready dips for one cycle, and the next full frame completes with correct data.
- Reset in HOLD and mid-LOAD: asserting rst for 1 cycle gives work_valid=0, work_data=0, err_count=0. work_ack pulses in HUNT/LOAD have no effect. 300 bad-nibble frames leave err_count=255.

Source files
------------

// File: rtl/work_loader.sv
// Byte-stream front end for the miner: finds a sync byte, assembles a 53-byte payload
// into the 420-bit work word and holds it until the miner acknowledges.
module work_loader #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         TIMEOUT   = 1000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic         rx_ready,
    output logic [419:0] work_data,
    output logic         work_valid,
    input  logic         work_ack,
    output logic [7:0]   err_count
);

    localparam int               GAP_W    = $clog2(TIMEOUT + 1);
    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(TIMEOUT);
    localparam logic [5:0]       LAST_IDX = 6'd52;

    typedef enum logic [1:0] {HUNT, LOAD, HOLD} state_t;

    state_t             state_q, state_d;
    logic [5:0]         idx_q, idx_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [411:0]       shift_q;
    logic [419:0]       shift_d;
    logic [419:0]       work_data_q, work_data_d;
    logic               work_valid_q, work_valid_d;
    logic [7:0]         err_q, err_d;
    logic               rx_ready_q, rx_ready_d;

    logic xfer, expire, bad_nib, last;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign xfer    = rx_valid && rx_ready_q;
    assign expire  = (state_q == LOAD) && (gap_q == GAP_MAX);
    assign bad_nib = (state_q == LOAD) && xfer && (idx_q == 6'd0) && (rx_data[7:4] != 4'h0);
    assign last    = (state_q == LOAD) && xfer && (idx_q == LAST_IDX);

    // Only the newest 420 bits survive; the mandatory-zero nibble of byte 0 falls off the top.
    assign shift_d = {shift_q, rx_data};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= HUNT;
            idx_q        <= '0;
            gap_q        <= '0;
            work_data_q  <= '0;
            work_valid_q <= 1'b0;
            err_q        <= '0;
            rx_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            gap_q        <= gap_d;
            work_data_q  <= work_data_d;
            work_valid_q <= work_valid_d;
            err_q        <= err_d;
            rx_ready_q   <= rx_ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if ((state_q == LOAD) && xfer) begin
            shift_q <= shift_d[411:0];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HUNT: begin
                if (xfer && (rx_data == SYNC_BYTE)) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (expire || bad_nib) begin
                    state_d = HUNT;
                end else if (last) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (work_ack) begin
                    state_d = HUNT;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_comb begin
        idx_d        = '0;
        gap_d        = '0;
        work_data_d  = work_data_q;
        work_valid_d = work_valid_q;
        err_d        = err_q;
        if ((state_q == LOAD) && (state_d == LOAD)) begin
            idx_d = xfer ? idx_q + 6'd1 : idx_q;
            gap_d = xfer ? '0 : gap_q + GAP_W'(1);
        end
        if (last) begin
            work_data_d  = shift_d;
            work_valid_d = 1'b1;
        end
        if ((state_q == HOLD) && work_ack) begin
            work_valid_d = 1'b0;
        end
        if (bad_nib || expire) begin
            err_d = sat_inc(err_q);
        end
        // Ready is registered, so the expiry cycle is predicted from the next gap value.
        rx_ready_d = (state_d == HUNT) || ((state_d == LOAD) && (gap_d != GAP_MAX));
    end

    assign rx_ready   = rx_ready_q;
    assign work_data  = work_data_q;
    assign work_valid = work_valid_q;
    assign err_count  = err_q;

endmodule
